// File: rtl/serial_rx.sv
// serial_rx: asynchronous serial line receiver (8N1 by default, LSB first).
// A 2-flop synchroniser, 3-sample majority vote at mid-bit, false-start
// rejection, framing error strobe and optional parity check.
// Optional feature macro: SERIAL_RX_PARITY_EN adds one parity bit after the
// data bits (sense chosen by ODD_PARITY); without it PARITY_ERR is tied low.
module serial_rx #(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SERIAL_IN,
    output logic [DATA_BITS-1:0] BYTE_OUT,
    output logic                 BYTE_RDY,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BT_W  = $clog2(OVERSAMPLE);
    localparam int NB_W  = 5;
    localparam int MID   = OVERSAMPLE / 2;

    generate
        if (CLK_DIV < 1 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
            DATA_BITS < 1 || DATA_BITS > 16 ||
            (ODD_PARITY != 0 && ODD_PARITY != 1)) begin : g_param_check
            $error("serial_rx: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rx_prev;
    logic [DIV_W-1:0]     r_div;
    logic [BT_W-1:0]      r_bt;
    logic [NB_W-1:0]      r_nbit;
    logic [1:0]           r_hist;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_tick;
    logic                 w_fall;
    logic                 w_vote;
    logic                 w_mid;
    logic                 w_wrap;
    logic                 w_start_det;
    logic                 w_shift_en;
    logic                 w_nbit_inc;
    logic                 w_load;
    logic                 w_ferr;
`ifdef SERIAL_RX_PARITY_EN
    logic                 r_par;
    logic                 w_par_en;
    logic                 w_par_mismatch;
`endif

    // Sample tick, falling-edge detect and majority of the last three samples
    // (the two stored ones plus the one being taken on this tick).
    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_fall = r_rx_prev & ~r_sync2;
    assign w_vote = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync2) | (r_hist[0] & r_sync2);
    assign w_mid  = w_tick && (r_bt == BT_W'(MID));
    assign w_wrap = w_tick && (r_bt == BT_W'(OVERSAMPLE - 1));

    // New data bit enters from the MSB side so the first (LSB) bit ends at bit 0.
    always_comb begin
        w_shift_next                = r_shift >> 1;
        w_shift_next[DATA_BITS-1]   = w_vote;
    end

    // Bring the asynchronous line into the clock domain; keep previous value for edge detect.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= SERIAL_IN;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Tick divider and bit/bit-count counters; all re-phased to the start edge.
    always_ff @(posedge CLK) begin
        if (RST || w_start_det) begin
            r_div  <= '0;
            r_bt   <= '0;
            r_nbit <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_bt <= (r_bt == BT_W'(OVERSAMPLE - 1)) ? '0 : r_bt + 1'b1;
            end
            if (w_nbit_inc) begin
                r_nbit <= r_nbit + 1'b1;
            end
        end
    end

    // Sample history and received-word shift register (data path, no reset needed).
    always_ff @(posedge CLK) begin
        if (w_tick) begin
            r_hist <= {r_hist[0], r_sync2};
        end
        if (w_shift_en) begin
            r_shift <= w_shift_next;
        end
`ifdef SERIAL_RX_PARITY_EN
        if (w_par_en) begin
            r_par <= w_vote;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and per-cycle action strobes.
    always_comb begin
        w_state_next = r_state;
        w_start_det  = 1'b0;
        w_shift_en   = 1'b0;
        w_nbit_inc   = 1'b0;
        w_load       = 1'b0;
        w_ferr       = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        w_par_en     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_start_det  = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_mid && w_vote) begin
                    w_state_next = S_IDLE;
                end else if (w_wrap) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_mid) begin
                    w_shift_en = 1'b1;
                end
                if (w_wrap) begin
                    if (r_nbit == NB_W'(DATA_BITS - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_nbit_inc = 1'b1;
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (w_mid) begin
                    w_par_en = 1'b1;
                end
                if (w_wrap) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-stop so the next start edge is caught even with rate mismatch.
                if (w_mid) begin
                    w_state_next = S_IDLE;
                    if (w_vote) begin
                        w_load = 1'b1;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Registered output word and one-cycle strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            BYTE_OUT  <= '0;
            BYTE_RDY  <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            BYTE_RDY  <= w_load;
            FRAME_ERR <= w_ferr;
            if (w_load) begin
                BYTE_OUT <= r_shift;
            end
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    assign w_par_mismatch = ((^r_shift) ^ r_par) != (ODD_PARITY != 0);

    // Parity error accompanies the delivered word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            PARITY_ERR <= 1'b0;
        end else begin
            PARITY_ERR <= w_load & w_par_mismatch;
        end
    end
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// Testbench for serial_rx: default-parameter instance plus a fast
// CLK_DIV=1 / OVERSAMPLE=4 / DATA_BITS=5 instance for the majority-vote case.
`timescale 1ns/1ps
module tb_serial_rx;
    localparam int CLK_DIV = 27;
    localparam int OVS     = 16;
    localparam int DB      = 8;
    localparam int P       = CLK_DIV * OVS;
`ifdef SERIAL_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SERIAL_IN = 1'b1;
    logic       SERIAL_IN2 = 1'b1;
    logic [7:0] BYTE_OUT;
    logic       BYTE_RDY, FRAME_ERR, PARITY_ERR;
    logic [4:0] BYTE_OUT2;
    logic       BYTE_RDY2, FRAME_ERR2, PARITY_ERR2;

    typedef struct {
        logic       rdy;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par_bad;
        int         gap_bits;
        logic       exp_rdy;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    exp_t       q[$];
    exp_t       q2[$];
    exp_t       e_m;
    exp_t       e_m2;
    vec_t       vecs[$];
    int         rdy_cyc[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;

    serial_rx #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OVS), .DATA_BITS(DB), .ODD_PARITY(0)) u_dut (
        .CLK(CLK), .RST(RST), .SERIAL_IN(SERIAL_IN), .BYTE_OUT(BYTE_OUT),
        .BYTE_RDY(BYTE_RDY), .FRAME_ERR(FRAME_ERR), .PARITY_ERR(PARITY_ERR));

    serial_rx #(.CLK_DIV(1), .OVERSAMPLE(4), .DATA_BITS(5), .ODD_PARITY(0)) u_maj (
        .CLK(CLK), .RST(RST), .SERIAL_IN(SERIAL_IN2), .BYTE_OUT(BYTE_OUT2),
        .BYTE_RDY(BYTE_RDY2), .FRAME_ERR(FRAME_ERR2), .PARITY_ERR(PARITY_ERR2));

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Main-instance monitor: each strobe cycle pops one expected event.
    always @(negedge CLK) begin
        if (!RST && (BYTE_RDY || FRAME_ERR || PARITY_ERR)) begin
            if (BYTE_RDY) rdy_cyc.push_back(cyc);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: rdy=%0b ferr=%0b perr=%0b, required no strobe",
                         BYTE_RDY, FRAME_ERR, PARITY_ERR);
            end else begin
                e_m = q.pop_front();
                chk("byte_rdy", 32'(BYTE_RDY), 32'(e_m.rdy));
                chk("frame_err", 32'(FRAME_ERR), 32'(e_m.ferr));
                chk("parity_err", 32'(PARITY_ERR), 32'(e_m.perr));
                chk("byte_out", 32'(BYTE_OUT), 32'(e_m.data));
            end
        end
    end

    // Majority-instance monitor.
    always @(negedge CLK) begin
        if (!RST && (BYTE_RDY2 || FRAME_ERR2 || PARITY_ERR2)) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL maj_unexpected_strobe: rdy=%0b ferr=%0b perr=%0b, required no strobe",
                         BYTE_RDY2, FRAME_ERR2, PARITY_ERR2);
            end else begin
                e_m2 = q2.pop_front();
                chk("maj_byte_rdy", 32'(BYTE_RDY2), 32'(e_m2.rdy));
                chk("maj_frame_err", 32'(FRAME_ERR2), 32'(e_m2.ferr));
                chk("maj_parity_err", 32'(PARITY_ERR2), 32'(e_m2.perr));
                chk("maj_byte_out", 32'({3'b000, BYTE_OUT2}), 32'(e_m2.data));
            end
        end
    end

    task automatic idle(input int n);
        SERIAL_IN = 1'b1;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_rdy(input logic [7:0] d, input logic perr);
        q.push_back('{1'b1, 1'b0, perr, d});
        last_good = d;
    endtask

    task automatic push_ferr();
        q.push_back('{1'b0, 1'b1, 1'b0, last_good});
    endtask

    // One frame on the main line; rst_bit >= 0 pulses RST mid that line bit,
    // hold_low extends a low line for that many extra bit periods.
    task automatic send(input logic [7:0] d, input logic stop_lvl, input logic par_bad,
                        input int rst_bit, input int hold_low);
        logic bits [0:11];
        int   nb;
        nb      = 2 + DB + NPAR;
        bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[1 + i] = d[i];
        if (NPAR != 0) bits[1 + DB] = (^d) ^ par_bad;
        bits[nb - 1] = stop_lvl;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < P; c++) begin
                SERIAL_IN = bits[b];
                RST       = (b == rst_bit) && (c == P / 2);
                @(posedge CLK);
                #1;
            end
        end
        RST = 1'b0;
        SERIAL_IN = 1'b0;
        repeat (hold_low * P) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Frame on the fast line with the centre sample of every data bit inverted.
    task automatic maj_send(input logic [4:0] d);
        logic bits [0:7];
        int   nb;
        nb      = 7 + NPAR;
        bits[0] = 1'b0;
        for (int i = 0; i < 5; i++) bits[1 + i] = d[i];
        if (NPAR != 0) bits[6] = ^d;
        bits[nb - 1] = 1'b1;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < 4; c++) begin
                SERIAL_IN2 = (b >= 1 && b <= 5 && c == 2) ? ~bits[b] : bits[b];
                @(posedge CLK);
                #1;
            end
        end
        SERIAL_IN2 = 1'b1;
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs.push_back('{8'hA5, 1'b0, 0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h3C, 1'b0, 1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 1'b0, 1, 1'b1, 1'b0, 1'b0});
`ifdef SERIAL_RX_PARITY_EN
        vecs.push_back('{8'h03, 1'b0, 1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h03, 1'b1, 1, 1'b1, 1'b0, 1'b1});
`endif

        RST = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_byte_out", 32'(BYTE_OUT), 32'h0);
        chk("rst_byte_rdy", 32'(BYTE_RDY), 32'h0);
        chk("rst_frame_err", 32'(FRAME_ERR), 32'h0);
        chk("rst_parity_err", 32'(PARITY_ERR), 32'h0);
        chk("rst_maj_byte_out", 32'(BYTE_OUT2), 32'h0);
        idle(P);

        foreach (vecs[i]) begin
            q.push_back('{vecs[i].exp_rdy, vecs[i].exp_ferr, vecs[i].exp_perr,
                          vecs[i].exp_rdy ? vecs[i].data : last_good});
            if (vecs[i].exp_rdy) last_good = vecs[i].data;
            send(vecs[i].data, 1'b1, vecs[i].par_bad, -1, 0);
            idle(vecs[i].gap_bits * P);
        end

        if (rdy_cyc.size() >= 4) begin
            chk("b2b_spacing_a5_3c", 32'(rdy_cyc[1] - rdy_cyc[0]), 32'((10 + NPAR) * P));
            chk("b2b_spacing_00_ff", 32'(rdy_cyc[3] - rdy_cyc[2]), 32'((10 + NPAR) * P));
        end else begin
            chk("b2b_rdy_count", 32'(rdy_cyc.size()), 32'd4);
        end

        // Short low glitch on an idle line must be rejected.
        SERIAL_IN = 1'b0;
        repeat (3 * CLK_DIV) begin
            @(posedge CLK);
            #1;
        end
        idle(2 * P);
        push_rdy(8'h55, 1'b0);
        send(8'h55, 1'b1, 1'b0, -1, 0);
        idle(P);

        // Stop bit low (break-like), then recovery.
        push_ferr();
        send(8'h81, 1'b0, 1'b0, -1, 2);
        chk("ferr_byte_out_held", 32'(BYTE_OUT), 32'h55);
        idle(P);
        push_rdy(8'h12, 1'b0);
        send(8'h12, 1'b1, 1'b0, -1, 0);
        idle(P);

        // Reset mid data bit 4 aborts the frame.
        send(8'hF8, 1'b1, 1'b0, 5, 0);
        chk("abort_byte_out", 32'(BYTE_OUT), 32'h0);
        chk("abort_byte_rdy", 32'(BYTE_RDY), 32'h0);
        last_good = 8'h00;
        idle(P);
        push_rdy(8'h7E, 1'b0);
        send(8'h7E, 1'b1, 1'b0, -1, 0);
        idle(P);

        // Majority vote survives a single corrupted sample per bit.
        q2.push_back('{1'b1, 1'b0, 1'b0, 8'h15});
        maj_send(5'h15);
        q2.push_back('{1'b1, 1'b0, 1'b0, 8'h0A});
        maj_send(5'h0A);
        repeat (20) @(posedge CLK);
        #1;

        n = 0;
        while ((q.size() != 0 || q2.size() != 0) && n < 2 * P) begin
            @(posedge CLK);
            n++;
        end
        chk("queue_drained", 32'(q.size() + q2.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_rx.md
# serial_rx

Parametrised asynchronous serial receiver: deserialises an 8N1-style (optionally 8E1/8O1) line into parallel words. It adds programmable baud divider, oversampling ratio and word width, a 2-flop input synchroniser, 3-sample majority voting, false-start rejection, and framing/parity error flags. It sits between the board's UART RX pin and the byte-consuming logic (command decoder, capture buffer), which receives one-cycle strobes.

## Interface
- CLK_DIV, 27: CLK cycles per sample tick (≥1).
- OVERSAMPLE, 16: sample ticks per bit (≥4, even).
- DATA_BITS, 8: data bits per frame (1..16), LSB first.
- ODD_PARITY, 0: parity sense when parity is compiled in (0 = even, 1 = odd).

- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- SERIAL_IN  in  1  asynchronous serial line, idle high.
- BYTE_OUT  out  DATA_BITS  last good word received.
- BYTE_RDY  out  1  one-cycle strobe: BYTE_OUT updated.
- FRAME_ERR  out  1  one-cycle strobe: stop bit sampled low.
- PARITY_ERR  out  1  one-cycle strobe: parity mismatch.

## Operation
- SERIAL_IN passes through 2 flops (reset to 1); all logic uses the synchronised value `rx_s`.
- Tick generator: counter 0..CLK_DIV-1; `tick` high for one CLK when the counter wraps. It free-runs in IDLE and is cleared on start detection, so bit timing phase-locks to the start edge.
- Each tick, `rx_s` shifts into a 3-bit history. A bit value is the majority of the history at tick index MID = OVERSAMPLE/2, i.e. samples MID-2..MID.
- Bit-tick counter `bt` runs 0..OVERSAMPLE-1 within each bit.
- States:
  - IDLE: on `rx_s` = 0 while the previous `rx_s` = 1 (falling edge), clear tick generator and `bt`, go to START.
  - START: at bt = MID, if the vote is 1, it is a false start: go to IDLE with no flags. Otherwise continue; at bt wrap, go to DATA.
  - DATA: at bt = MID, shift the vote into the shift register from the MSB side (LSB first on the line). After DATA_BITS bits, go to PARITY (macro defined) or STOP.
  - PARITY: at bt = MID, record the vote; at wrap, go to STOP.
  - STOP: at bt = MID:
    - If the vote is 1: load BYTE_OUT, pulse BYTE_RDY, and pulse PARITY_ERR if there is a mismatch.
    - If the vote is 0: pulse FRAME_ERR; BYTE_OUT is unchanged and BYTE_RDY stays low.
    - In both cases go to IDLE immediately (half-bit early, tolerating ±~4% rate mismatch).
- After FRAME_ERR (for example a break), IDLE requires `rx_s` to return high before a new falling edge is accepted.
- RST asserted in any state, including mid-frame: next cycle state = IDLE, counters 0, all outputs at reset value, partial word discarded.

## Timing
- Reset values: BYTE_OUT = 0, BYTE_RDY = 0, FRAME_ERR = 0, PARITY_ERR = 0.
- Bit period = CLK_DIV × OVERSAMPLE CLK cycles (defaults: 432, i.e. 115 741 bps at 50 MHz).
- Input latency: 2 CLK (synchroniser) plus up to 1 CLK (edge register).
- BYTE_RDY / FRAME_ERR / PARITY_ERR are registered. They assert 1 CLK after the stop-bit MID tick, i.e. (1 + DATA_BITS [+1 parity]) × bit period + MID × CLK_DIV + ~3 CLK after the start edge.
- Strobes are exactly 1 CLK wide. BYTE_RDY and FRAME_ERR are never high together. PARITY_ERR is only ever high together with BYTE_RDY.
- BYTE_OUT is stable from the BYTE_RDY cycle until the next BYTE_RDY. There is no backpressure; the consumer must take the word before the next frame completes (≥ 1 frame time).
- Back-to-back frames with zero idle gap are received without loss.

## Configuration
- SERIAL_RX_PARITY_EN defined:
  - The PARITY state exists; one parity bit follows the data bits.
  - Parity is checked against ODD_PARITY (even: XOR of data and parity = 0).
  - A mismatch pulses PARITY_ERR with BYTE_RDY; the word is still delivered.
- Not defined:
  - The frame has no parity bit (DATA → STOP).
  - PARITY_ERR is tied to 0.

## Test plan
- Defaults, 8N1, send 0xA5 then 0x3C back-to-back → two BYTE_RDY pulses with BYTE_OUT = 0xA5 then 0x3C, spaced exactly 10 × 432 CLK apart; FRAME_ERR stays 0.
- Low glitch of 3 × CLK_DIV cycles on an idle line → no strobes; the next valid frame 0x55 is received correctly.
- Frame 0x81 with its stop bit held low, line released 2 bit-times later, then 0x12 → one FRAME_ERR pulse, BYTE_OUT stays at its prior value, then BYTE_RDY with 0x12.
- RST asserted for 1 CLK mid-data-bit 4 of a frame, then a clean 0x7E → no strobe for the aborted frame; BYTE_RDY with 0x7E.
- SERIAL_RX_PARITY_EN, ODD_PARITY = 0: send 0x03 with parity 0 → BYTE_RDY, PARITY_ERR = 0. Send 0x03 with parity 1 → BYTE_RDY and PARITY_ERR in the same cycle, BYTE_OUT = 0x03.
- CLK_DIV = 1, OVERSAMPLE = 4, DATA_BITS = 5, single-sample inversion at the centre of each data bit of 0x15 → majority vote yields BYTE_OUT = 0x15.
